// File: rtl/excess3_to_binary_seq_pkg.sv
// Shared definitions for the lab code-converter family: FSM states, digit
// range limits and the reverse double-dabble correction step.
package lab_conv_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_SHIFT,
    S_DONE
  } conv_state_e;

  localparam logic [3:0] EX3_OFFSET  = 4'd3;
  localparam logic [3:0] EX3_LO      = 4'b0011;
  localparam logic [3:0] EX3_HI      = 4'b1100;
  localparam logic [3:0] BCD_MAX     = 4'b1001;
  localparam logic [3:0] CORR_THRESH = 4'd8;

  // After a right shift, a BCD digit of 8 or more carried a 10 that became 8.
  function automatic logic [3:0] dabble_fix(input logic [3:0] d);
    return (d >= CORR_THRESH) ? (d - EX3_OFFSET) : d;
  endfunction

endpackage

// File: rtl/excess3_digit_norm.sv
// Single-digit normaliser: maps an Excess-3 or BCD digit to BCD and flags
// codes outside the legal range for the selected mode.
module excess3_digit_norm
  import lab_conv_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       mode_i,
  output logic [3:0] bcd_o,
  output logic       illegal_o
);

  always_comb begin
    bcd_o     = digit_i;
    illegal_o = 1'b0;
    if (mode_i) begin
      illegal_o = (digit_i > BCD_MAX);
    end else begin
      illegal_o = (digit_i < EX3_LO) || (digit_i > EX3_HI);
      bcd_o     = digit_i - EX3_OFFSET;
    end
  end

endmodule

// File: rtl/excess3_to_binary_seq.sv
// Sequential multi-digit Excess-3/BCD to binary converter using reverse
// double-dabble, with start/busy/done handshake and per-digit error mask.
module excess3_to_binary_seq
  import lab_conv_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  mode_i,
  input  logic [4*DIGITS-1:0]   e_i,
  output logic [4*DIGITS-1:0]   b_o,
  output logic                  v_o,
  output logic [DIGITS-1:0]     err_mask_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(W);

  conv_state_e         state_q, state_d;
  logic [W-1:0]        e_q, e_d;
  logic                mode_q, mode_d;
  logic [2*W-1:0]      sr_q, sr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [W-1:0]        b_q, b_d;
  logic                v_q, v_d;
  logic [DIGITS-1:0]   mask_q, mask_d;

  logic [W-1:0]        bcd_norm;
  logic [DIGITS-1:0]   illegal;
  logic [2*W-1:0]      sr_shift;
  logic [2*W-1:0]      sr_step;

  for (genvar i = 0; i < DIGITS; i++) begin : g_norm
    excess3_digit_norm u_norm (
      .digit_i   (e_q[4*i +: 4]),
      .mode_i    (mode_q),
      .bcd_o     (bcd_norm[4*i +: 4]),
      .illegal_o (illegal[i])
    );
  end

  // Upper half holds the BCD digits, lower half collects binary from the MSB down.
  always_comb begin
    sr_shift = sr_q >> 1;
    sr_step  = sr_shift;
    for (int i = 0; i < DIGITS; i++) begin
      sr_step[W + 4*i +: 4] = dabble_fix(sr_shift[W + 4*i +: 4]);
    end
  end

  always_comb begin
    state_d = state_q;
    e_d     = e_q;
    mode_d  = mode_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    b_d     = b_q;
    v_d     = v_q;
    mask_d  = mask_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          e_d     = e_i;
          mode_d  = mode_i;
          state_d = S_CHECK;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CHECK: begin
        if (|illegal) begin
          b_d     = '0;
          v_d     = 1'b0;
          mask_d  = illegal;
          state_d = S_DONE;
        end else begin
          sr_d    = {bcd_norm, {W{1'b0}}};
          cnt_d   = CW'(W - 1);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sr_d = sr_step;
        if (cnt_q == '0) begin
          b_d     = sr_step[W-1:0];
          v_d     = 1'b1;
          mask_d  = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      e_q     <= '0;
      mode_q  <= 1'b0;
      sr_q    <= '0;
      cnt_q   <= '0;
      b_q     <= '0;
      v_q     <= 1'b0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      e_q     <= e_d;
      mode_q  <= mode_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      b_q     <= b_d;
      v_q     <= v_d;
      mask_q  <= mask_d;
    end
  end

  assign b_o        = b_q;
  assign v_o        = v_q;
  assign err_mask_o = mask_q;
  assign busy_o     = (state_q == S_CHECK) || (state_q == S_SHIFT);
  assign done_o     = (state_q == S_DONE);

endmodule

// File: tb/tb_excess3_to_binary_seq.sv
// Directed bench for excess3_to_binary_seq: expected results come from a
// decimal-arithmetic model and are queued per start, popped on each done.
module tb_excess3_to_binary_seq;

  typedef struct packed {
    logic [15:0] b;
    logic        v;
    logic [3:0]  m;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start4, mode4, start1, mode1;
  logic [15:0] e4;
  logic [3:0]  e1;
  logic [15:0] b4;
  logic [3:0]  b1;
  logic        v4, v1, busy4, busy1, done4, done1;
  logic [3:0]  m4;
  logic [0:0]  m1;

  exp_t q4[$];
  exp_t q1[$];
  exp_t x4, x1, hold_exp;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt4 = 0;
  int   done_cnt1 = 0;
  logic prev_done4 = 1'b0;
  logic prev_done1 = 1'b0;
  int   cnt_before, lat;

  always #5 clk = ~clk;

  excess3_to_binary_seq #(.DIGITS(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(start4), .mode_i(mode4), .e_i(e4),
    .b_o(b4), .v_o(v4), .err_mask_o(m4), .busy_o(busy4), .done_o(done4)
  );

  excess3_to_binary_seq #(.DIGITS(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .mode_i(mode1), .e_i(e1),
    .b_o(b1), .v_o(v1), .err_mask_o(m1), .busy_o(busy1), .done_o(done1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Decimal reference: accumulate digit values base 10, flag out-of-range digits.
  function automatic exp_t model(input int nd, input logic md, input logic [15:0] e);
    exp_t r;
    int   val;
    int   dv;
    r   = '0;
    val = 0;
    for (int i = nd - 1; i >= 0; i--) begin
      dv = md ? int'(e[4*i +: 4]) : int'(e[4*i +: 4]) - 3;
      if (dv < 0 || dv > 9) r.m[i] = 1'b1;
      val = val * 10 + dv;
    end
    if (r.m == 4'b0) begin
      r.v = 1'b1;
      r.b = val[15:0];
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (prev_done4) check("done4_one_cycle", done4, 1'b0);
    if (done4 === 1'b1) begin
      done_cnt4++;
      if (q4.size() == 0) begin
        check("done4_unexpected", done4, 1'b0);
      end else begin
        x4 = q4.pop_front();
        check("b4", b4, x4.b);
        check("v4", v4, x4.v);
        check("mask4", m4, x4.m);
      end
    end
    prev_done4 = done4;
  end

  always @(negedge clk) begin
    if (prev_done1) check("done1_one_cycle", done1, 1'b0);
    if (done1 === 1'b1) begin
      done_cnt1++;
      if (q1.size() == 0) begin
        check("done1_unexpected", done1, 1'b0);
      end else begin
        x1 = q1.pop_front();
        check("b1", b1, x1.b);
        check("v1", v1, x1.v);
        check("mask1", m1, x1.m);
      end
    end
    prev_done1 = done1;
  end

  // Called at a negedge; returns at the negedge where done is visible.
  task automatic run4(input logic md, input logic [15:0] e);
    exp_t x;
    int   n;
    x = model(4, md, e);
    q4.push_back(x);
    mode4  = md;
    e4     = e;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    mode4  = ~md;
    e4     = ~e;
    n      = 1;
    check("busy_after_start", busy4, 1'b1);
    while (done4 !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, x.v ? 18 : 2);
    check("busy_at_done", busy4, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start4 = 1'b0; mode4 = 1'b0; e4 = '0;
    start1 = 1'b0; mode1 = 1'b0; e1 = '0;
    repeat (3) @(negedge clk);
    check("rst_b", b4, 16'h0);
    check("rst_v", v4, 1'b0);
    check("rst_mask", m4, 4'h0);
    check("rst_busy", busy4, 1'b0);
    check("rst_done", done4, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    run4(1'b0, 16'h4567);
    @(negedge clk);
    run4(1'b0, 16'hCCCC);
    @(negedge clk);
    run4(1'b0, 16'h3333);
    @(negedge clk);
    run4(1'b0, 16'h406F);
    @(negedge clk);
    run4(1'b1, 16'h1234);
    @(negedge clk);
    run4(1'b1, 16'h12A4);
    hold_exp = model(4, 1'b1, 16'h12A4);
    repeat (3) @(negedge clk);
    check("hold_mask", m4, hold_exp.m);
    check("hold_v", v4, hold_exp.v);

    // Back-to-back: second start lands in the done cycle of the first.
    @(negedge clk);
    run4(1'b0, 16'h4567);
    run4(1'b1, 16'h0987);

    // A start pulse during busy must not launch a second conversion.
    @(negedge clk);
    cnt_before = done_cnt4;
    q4.push_back(model(4, 1'b1, 16'h1234));
    mode4 = 1'b1; e4 = 16'h1234; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (4) @(negedge clk);
    e4 = 16'h9999; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    lat = 0;
    while (done4 !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("busy_start_done_seen", done4, 1'b1);
    repeat (25) @(negedge clk);
    check("busy_start_ignored", done_cnt4 - cnt_before, 1);

    // Reset in the middle of a conversion: outputs clear, no done follows.
    cnt_before = done_cnt4;
    mode4 = 1'b0; e4 = 16'h4567; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (7) @(negedge clk);
    check("pre_rst_busy", busy4, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_b", b4, 16'h0);
    check("midrst_v", v4, 1'b0);
    check("midrst_mask", m4, 4'h0);
    check("midrst_busy", busy4, 1'b0);
    check("midrst_done", done4, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    check("midrst_no_done", done_cnt4 - cnt_before, 0);
    run4(1'b0, 16'hCCCC);

    // Single-digit sweep over every code in Excess-3 mode.
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      q1.push_back(model(1, 1'b0, {12'h000, 4'(c)}));
      mode1 = 1'b0; e1 = 4'(c); start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      lat = 1;
      while (done1 !== 1'b1 && lat < 50) begin
        @(negedge clk);
        lat++;
      end
      check("d1_done_seen", done1, 1'b1);
    end

    repeat (3) @(negedge clk);
    check("q4_drained", q4.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
